// File: rtl/snake_engine.sv
// Snake body engine: segment array, one-cell step per tick, sequential self-collision scan; WRAP_WALLS_EN wraps walls.
// Latency: step completes len-1 (+1 when growing) scan cycles plus one move cycle after tick; query port is 1 cycle.
// Backpressure: none; ticks outside RUN are dropped, start is ignored while RUN/SCAN.
module snake_engine #(
  parameter int GRID_W   = 40,
  parameter int GRID_H   = 30,
  parameter int MAX_LEN  = 64,
  parameter int INIT_LEN = 3,
  localparam int X_W = $clog2(GRID_W),
  localparam int Y_W = $clog2(GRID_H),
  localparam int L_W = $clog2(MAX_LEN + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           tick,
  input  logic           dir_valid,
  input  logic [1:0]     dir,
  input  logic [X_W-1:0] food_x,
  input  logic [Y_W-1:0] food_y,
  input  logic [X_W-1:0] q_x,
  input  logic [Y_W-1:0] q_y,
  output logic           q_body,
  output logic           q_head,
  output logic [X_W-1:0] head_x,
  output logic [Y_W-1:0] head_y,
  output logic [L_W-1:0] len,
  output logic           ate,
  output logic           dead,
  output logic [1:0]     status,
  output logic [15:0]    score
);

`ifdef WRAP_WALLS_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  localparam int I_W = $clog2(MAX_LEN);

  localparam logic [1:0] D_UP    = 2'd0;
  localparam logic [1:0] D_DOWN  = 2'd1;
  localparam logic [1:0] D_LEFT  = 2'd2;
  localparam logic [1:0] D_RIGHT = 2'd3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_SCAN = 2'd2;
  localparam logic [1:0] ST_DEAD = 2'd3;

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_SCAN, S_MOVE, S_DEAD} state_t;

  state_t           state;
  logic [X_W-1:0]   seg_x [MAX_LEN];
  logic [Y_W-1:0]   seg_y [MAX_LEN];
  logic [1:0]       cur_dir;
  logic [1:0]       pend_dir;
  logic [X_W-1:0]   nh_x;
  logic [Y_W-1:0]   nh_y;
  logic             grow;
  logic [I_W-1:0]   idx;

  logic [X_W-1:0]   cand_x;
  logic [Y_W-1:0]   cand_y;
  logic             wall;
  logic             tick_go;
  logic [1:0]       ref_dir;
  logic             dir_accept;
  logic [L_W-1:0]   scan_last;
  logic             scan_done;
  logic             hit;
  logic             q_any;

  function automatic logic [X_W-1:0] init_x(int i);
    return (i < INIT_LEN) ? X_W'(GRID_W / 2 - i) : '0;
  endfunction

  function automatic logic [Y_W-1:0] init_y(int i);
    return (i < INIT_LEN) ? Y_W'(GRID_H / 2) : '0;
  endfunction

  assign head_x = seg_x[0];
  assign head_y = seg_y[0];

  // Candidate head one cell ahead in the pending direction; wall flags an out-of-grid step.
  always_comb begin
    cand_x = seg_x[0];
    cand_y = seg_y[0];
    wall   = 1'b0;
    case (pend_dir)
      D_UP: begin
        if (seg_y[0] == '0) begin
          wall   = 1'b1;
          cand_y = Y_W'(GRID_H - 1);
        end else begin
          cand_y = seg_y[0] - Y_W'(1);
        end
      end
      D_DOWN: begin
        if (seg_y[0] == Y_W'(GRID_H - 1)) begin
          wall   = 1'b1;
          cand_y = '0;
        end else begin
          cand_y = seg_y[0] + Y_W'(1);
        end
      end
      D_LEFT: begin
        if (seg_x[0] == '0) begin
          wall   = 1'b1;
          cand_x = X_W'(GRID_W - 1);
        end else begin
          cand_x = seg_x[0] - X_W'(1);
        end
      end
      D_RIGHT: begin
        if (seg_x[0] == X_W'(GRID_W - 1)) begin
          wall   = 1'b1;
          cand_x = '0;
        end else begin
          cand_x = seg_x[0] + X_W'(1);
        end
      end
    endcase
  end

  // On the tick cycle the committed direction is pend_dir, so reversals are judged against it.
  assign tick_go    = (state == S_RUN) && tick;
  assign ref_dir    = tick_go ? pend_dir : cur_dir;
  assign dir_accept = dir_valid && (dir != (ref_dir ^ 2'b01));

  // Without growth the tail cell vacates during the move, so it is excluded from the scan.
  assign scan_last = grow ? (len - L_W'(1)) : (len - L_W'(2));
  assign scan_done = (L_W'(idx) == scan_last);
  assign hit       = (seg_x[idx] == nh_x) && (seg_y[idx] == nh_y);

  always_comb begin
    q_any = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((L_W'(i) < len) && (seg_x[i] == q_x) && (seg_y[i] == q_y)) begin
        q_any = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      status   <= ST_IDLE;
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x[i] <= init_x(i);
        seg_y[i] <= init_y(i);
      end
      cur_dir  <= D_RIGHT;
      pend_dir <= D_RIGHT;
      len      <= L_W'(INIT_LEN);
      score    <= '0;
      ate      <= 1'b0;
      dead     <= 1'b0;
      q_body   <= 1'b0;
      q_head   <= 1'b0;
      nh_x     <= '0;
      nh_y     <= '0;
      grow     <= 1'b0;
      idx      <= '0;
    end else begin
      q_head <= (seg_x[0] == q_x) && (seg_y[0] == q_y);
      q_body <= q_any;
      ate    <= 1'b0;
      if (dir_accept) begin
        pend_dir <= dir;
      end
      case (state)
        S_IDLE, S_DEAD: begin
          if (start) begin
            for (int i = 0; i < MAX_LEN; i++) begin
              seg_x[i] <= init_x(i);
              seg_y[i] <= init_y(i);
            end
            cur_dir  <= D_RIGHT;
            pend_dir <= D_RIGHT;
            len      <= L_W'(INIT_LEN);
            score    <= '0;
            dead     <= 1'b0;
            state    <= S_RUN;
            status   <= ST_RUN;
          end
        end
        S_RUN: begin
          if (tick) begin
            cur_dir <= pend_dir;
            if (wall && !WRAP) begin
              state  <= S_DEAD;
              status <= ST_DEAD;
              dead   <= 1'b1;
            end else begin
              nh_x   <= cand_x;
              nh_y   <= cand_y;
              grow   <= (cand_x == food_x) && (cand_y == food_y);
              idx    <= '0;
              state  <= S_SCAN;
              status <= ST_SCAN;
            end
          end
        end
        S_SCAN: begin
          if (hit) begin
            state  <= S_DEAD;
            status <= ST_DEAD;
            dead   <= 1'b1;
          end else if (scan_done) begin
            state <= S_MOVE;
          end else begin
            idx <= idx + I_W'(1);
          end
        end
        S_MOVE: begin
          for (int i = 1; i < MAX_LEN; i++) begin
            seg_x[i] <= seg_x[i-1];
            seg_y[i] <= seg_y[i-1];
          end
          seg_x[0] <= nh_x;
          seg_y[0] <= nh_y;
          if (grow) begin
            ate <= 1'b1;
            if (len != L_W'(MAX_LEN)) begin
              len <= len + L_W'(1);
            end
            if (score != 16'hFFFF) begin
              score <= score + 16'd1;
            end
          end
          state  <= S_RUN;
          status <= ST_RUN;
        end
        default: begin
          state  <= S_IDLE;
          status <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
